// File: rtl/usb_rx_decoder.sv
// rtl/usb_rx_decoder.sv - full-speed USB receive decoder (sync, NRZI, unstuff, PID, EOP)
//
// Ports:
//   clk, n_rst            system clock, asynchronous active-low reset
//   Dplus_in, Dminus_in   raw differential line
//   buffer_occupancy      bytes currently held in the shared data buffer
//   rx_packet             PID nibble of the last accepted packet
//   rx_data_ready         1-cycle pulse: packet received without error
//   rx_transfer_active    high while a packet is in flight
//   rx_error              sticky error flag, cleared at the next SYNC start
//   flush                 1-cycle pulse before a DATA payload
//   store_rx_packet_data  1-cycle pulse: rx_packet_data is a payload byte
//   rx_packet_data        assembled payload byte
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int BUF_DEPTH    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       Dplus_in,
    input  logic       Dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [3:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       flush,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_EOP_J, S_ERR} state_t;

    state_t        state;
    logic          dp_s1, dp_s2, dp_d, dm_s1, dm_s2, dm_d;
    logic [TW-1:0] timer;
    logic          prev_level;
    logic [2:0]    bit_cnt, ones_cnt, err_jcnt;
    logic [7:0]    shift;
    logic          err_se0;

    logic       line_j, line_k, line_se0, line_se1;
    logic       dp_edge, start_edge, sample;
    logic       dec_bit, stuff_drop, stuff_err, byte_err, go_err;
    logic [7:0] next_byte;

    // Synchronizer resets to J so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_s1 <= 1'b1; dp_s2 <= 1'b1; dp_d <= 1'b1;
            dm_s1 <= 1'b0; dm_s2 <= 1'b0; dm_d <= 1'b0;
        end else begin
            dp_s1 <= Dplus_in;  dp_s2 <= dp_s1; dp_d <= dp_s2;
            dm_s1 <= Dminus_in; dm_s2 <= dm_s1; dm_d <= dm_s2;
        end
    end

    assign line_j     = dp_s2 & ~dm_s2;
    assign line_k     = ~dp_s2 & dm_s2;
    assign line_se0   = ~dp_s2 & ~dm_s2;
    assign line_se1   = dp_s2 & dm_s2;
    assign dp_edge    = dp_s2 ^ dp_d;
    assign start_edge = dp_d & ~dm_d & line_k;

    // The edge cycle counts as 0, so the sample lands mid-bit on every D+ transition.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)            timer <= '0;
        else if (dp_edge)      timer <= TW'(1);
        else if (timer == LAST) timer <= '0;
        else                   timer <= timer + TW'(1);
    end
    assign sample = (timer == HALF) && !dp_edge;

    assign dec_bit    = (dp_s2 == prev_level);
    assign stuff_drop = (ones_cnt == 3'd6) && !dec_bit;
    assign stuff_err  = (ones_cnt == 3'd6) && dec_bit;
    assign next_byte  = {dec_bit, shift[7:1]};

    always_comb begin
        byte_err = 1'b0;
        case (state)
            S_SYNC:  byte_err = (next_byte != 8'h80);
            S_PID:   byte_err = (next_byte[7:4] != ~next_byte[3:0]);
            S_DATA:  byte_err = (buffer_occupancy == 7'(BUF_DEPTH));
            default: byte_err = 1'b0;
        endcase
    end

    always_comb begin
        go_err = 1'b0;
        if (sample) begin
            case (state)
                S_SYNC, S_PID, S_DATA: begin
                    if (line_se1)                              go_err = 1'b1;
                    else if (line_se0)                         go_err = (state != S_DATA) || (bit_cnt != 3'd0);
                    else if (stuff_err)                        go_err = 1'b1;
                    else if (!stuff_drop && bit_cnt == 3'd7)   go_err = byte_err;
                end
                S_EOP:   go_err = !line_se0;
                S_EOP_J: go_err = !line_j;
                default: go_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= S_IDLE;
            prev_level           <= 1'b1;
            bit_cnt              <= '0;
            ones_cnt             <= '0;
            shift                <= '0;
            err_se0              <= 1'b0;
            err_jcnt             <= '0;
            rx_packet            <= '0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= '0;
        end else begin
            rx_data_ready        <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            if (go_err) begin
                state    <= S_ERR;
                rx_error <= 1'b1;
                // An SE0 that caused the error still counts toward the SE0->J recovery.
                err_se0  <= line_se0;
                err_jcnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        prev_level <= 1'b1;
                        bit_cnt    <= '0;
                        ones_cnt   <= '0;
                        if (start_edge) begin
                            state              <= S_SYNC;
                            rx_transfer_active <= 1'b1;
                            rx_error           <= 1'b0;
                        end
                    end
                    S_SYNC, S_PID, S_DATA: if (sample) begin
                        if (line_se0) begin
                            state <= S_EOP_J;   // only clean SE0 (DATA, byte boundary) gets here
                        end else begin
                            prev_level <= dp_s2;
                            if (stuff_drop) begin
                                ones_cnt <= '0;
                            end else begin
                                ones_cnt <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
                                shift    <= next_byte;
                                bit_cnt  <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    case (state)
                                        S_SYNC: state <= S_PID;
                                        S_PID: begin
                                            rx_packet <= next_byte[3:0];
                                            if (next_byte[1:0] == 2'b11) begin
                                                flush <= 1'b1;
                                                state <= S_DATA;
                                            end else begin
                                                state <= S_EOP;
                                            end
                                        end
                                        default: begin
                                            store_rx_packet_data <= 1'b1;
                                            rx_packet_data       <= next_byte;
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                    S_EOP: if (sample) state <= S_EOP_J;
                    S_EOP_J: if (sample) begin
                        rx_data_ready      <= 1'b1;
                        rx_transfer_active <= 1'b0;
                        state              <= S_IDLE;
                    end
                    S_ERR: if (sample) begin
                        err_se0 <= line_se0;
                        if (line_j && (err_se0 || err_jcnt == 3'd7)) begin
                            rx_transfer_active <= 1'b0;
                            state              <= S_IDLE;
                        end else if (line_j) begin
                            err_jcnt <= err_jcnt + 3'd1;
                        end else begin
                            err_jcnt <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb/tb_usb_rx_decoder.sv - directed and random packet bench for usb_rx_decoder
module tb_usb_rx_decoder;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       Dplus_in, Dminus_in;
    logic [6:0] buffer_occupancy;
    logic [3:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
    logic [7:0] rx_packet_data;

    usb_rx_decoder #(.CLKS_PER_BIT(8), .BUF_DEPTH(64)) dut (
        .clk(clk), .n_rst(n_rst), .Dplus_in(Dplus_in), .Dminus_in(Dminus_in),
        .buffer_occupancy(buffer_occupancy), .rx_packet(rx_packet),
        .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
        .rx_error(rx_error), .flush(flush), .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data(rx_packet_data)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] L_J = 2'b10, L_K = 2'b01, L_SE0 = 2'b00;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse monitor: the only writer of these counters.
    int         flush_cnt = 0, ready_cnt = 0, overlap_cnt = 0, ready_err_cnt = 0;
    logic [7:0] store_q[$];
    always @(negedge clk) begin
        if (flush) flush_cnt++;
        if (rx_data_ready) ready_cnt++;
        if (store_rx_packet_data) store_q.push_back(rx_packet_data);
        if (flush && store_rx_packet_data) overlap_cnt++;
        if (rx_data_ready && rx_error) ready_err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit model: bytes -> LSB-first bits -> stuffing -> NRZI line symbols.
    logic [1:0] sym_q[$];
    logic       tx_level;
    int         tx_ones;

    task automatic tx_begin();
        sym_q.delete();
        tx_level = 1'b1;
        tx_ones  = 0;
    endtask

    task automatic tx_bit(input logic b);
        if (b) tx_ones++;
        else begin
            tx_level = ~tx_level;
            tx_ones  = 0;
        end
        sym_q.push_back(tx_level ? L_J : L_K);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx_bit(b[i]);
            if (tx_ones == 6) tx_bit(1'b0);
        end
    endtask

    task automatic tx_raw(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tx_bit(b[i]);
    endtask

    task automatic tx_eop();
        sym_q.push_back(L_SE0);
        tx_level = 1'b1;
        for (int i = 0; i < 3; i++) sym_q.push_back(L_J);
    endtask

    task automatic play(input int limit);
        for (int i = 0; i < sym_q.size() && i < limit; i++) begin
            {Dplus_in, Dminus_in} = sym_q[i];
            repeat (8) @(negedge clk);
        end
        {Dplus_in, Dminus_in} = L_J;
    endtask

    // Byte-level reference model.
    logic [7:0] payload_q[$];
    logic [7:0] exp_q[$];
    logic [3:0] exp_pkt = 4'h0;

    task automatic model(input logic [7:0] pid, input logic [6:0] occ,
                         output logic e_err, output int e_ready, output int e_flush);
        exp_q.delete();
        if (pid[7:4] != ~pid[3:0]) begin
            e_err = 1'b1; e_ready = 0; e_flush = 0;
        end else begin
            exp_pkt = pid[3:0];
            if (pid[1:0] == 2'b11) begin
                e_flush = 1;
                if (payload_q.size() > 0 && occ == 7'd64) begin
                    e_err = 1'b1; e_ready = 0;
                end else begin
                    exp_q = payload_q; e_err = 1'b0; e_ready = 1;
                end
            end else begin
                e_flush = 0;
                e_err   = (payload_q.size() != 0);
                e_ready = e_err ? 0 : 1;
            end
        end
    endtask

    task automatic check_pkt(input string tag, input int f0, input int r0, input int s0,
                             input logic e_err, input int e_ready, input int e_flush);
        chk({tag, ".rx_error"}, rx_error, e_err);
        chk({tag, ".ready_pulses"}, ready_cnt - r0, e_ready);
        chk({tag, ".flush_pulses"}, flush_cnt - f0, e_flush);
        chk({tag, ".store_pulses"}, store_q.size() - s0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (s0 + i < store_q.size())
                chk($sformatf("%s.store%0d", tag, i), store_q[s0 + i], exp_q[i]);
        chk({tag, ".rx_packet"}, rx_packet, exp_pkt);
        chk({tag, ".active"}, rx_transfer_active, 1'b0);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] pid, input logic [6:0] occ);
        logic e_err;
        int   e_ready, e_flush, f0, r0, s0;
        model(pid, occ, e_err, e_ready, e_flush);
        tx_begin();
        tx_byte(8'h80);
        tx_byte(pid);
        foreach (payload_q[i]) tx_byte(payload_q[i]);
        tx_eop();
        buffer_occupancy = occ;
        f0 = flush_cnt; r0 = ready_cnt; s0 = store_q.size();
        play(sym_q.size());
        repeat (96) @(negedge clk);
        check_pkt(tag, f0, r0, s0, e_err, e_ready, e_flush);
    endtask

    // Directed DATA0 packet with a malformed tail; always expected to error after a flush.
    task automatic send_bad_data(input string tag, input logic [7:0] raw, input int nbits);
        int f0, r0, s0;
        tx_begin();
        tx_byte(8'h80);
        tx_byte(8'hC3);
        tx_raw(raw, nbits);
        tx_eop();
        exp_q.delete();
        exp_pkt = 4'h3;
        buffer_occupancy = 7'd0;
        f0 = flush_cnt; r0 = ready_cnt; s0 = store_q.size();
        play(sym_q.size());
        repeat (96) @(negedge clk);
        check_pkt(tag, f0, r0, s0, 1'b1, 0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".rx_packet"}, rx_packet, 4'h0);
        chk({tag, ".ready"}, rx_data_ready, 1'b0);
        chk({tag, ".active"}, rx_transfer_active, 1'b0);
        chk({tag, ".error"}, rx_error, 1'b0);
        chk({tag, ".flush"}, flush, 1'b0);
        chk({tag, ".store"}, store_rx_packet_data, 1'b0);
        chk({tag, ".data"}, rx_packet_data, 8'h00);
    endtask

    logic [7:0] hs_pids[3] = '{8'hD2, 8'h5A, 8'h1E};

    initial begin
        logic [7:0] pid;
        logic [6:0] occ;
        int         n;

        n_rst = 1'b0;
        {Dplus_in, Dminus_in} = L_J;
        buffer_occupancy = 7'd0;
        repeat (4) @(negedge clk);
        chk_outputs_zero("reset");
        n_rst = 1'b1;
        repeat (16) @(negedge clk);

        payload_q.delete();
        send_and_check("ack", 8'hD2, 7'd0);

        payload_q = '{8'h3F, 8'hFF, 8'h00};
        send_and_check("data0", 8'hC3, 7'd5);

        payload_q.delete();
        send_and_check("bad_pid", 8'hD3, 7'd0);
        send_and_check("ack_after_err", 8'hD2, 7'd0);

        send_bad_data("stuff_err", 8'hFF, 8);

        payload_q = '{8'hA5, 8'h5A};
        send_and_check("overflow", 8'h4B, 7'd64);

        send_bad_data("short_se0", 8'h15, 5);

        // Reset in the middle of the PID byte.
        payload_q.delete();
        tx_begin();
        tx_byte(8'h80);
        tx_byte(8'hD2);
        tx_eop();
        play(12);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("mid_reset");
        exp_pkt = 4'h0;
        n_rst = 1'b1;
        repeat (16) @(negedge clk);
        payload_q = '{8'h12, 8'hFE, 8'h7F, 8'h80};
        send_and_check("post_reset", 8'hC3, 7'd10);

        for (int p = 0; p < 16; p++) begin
            case ($urandom_range(0, 3))
                0:       pid = 8'hC3;
                1:       pid = 8'h4B;
                2:       pid = hs_pids[$urandom_range(0, 2)];
                default: pid = 8'($urandom);
            endcase
            payload_q.delete();
            n = (pid[1:0] == 2'b11 || $urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
            for (int i = 0; i < n; i++) payload_q.push_back(8'($urandom));
            occ = ($urandom_range(0, 4) == 0) ? 7'd64 : 7'($urandom_range(0, 63));
            send_and_check($sformatf("rand%0d", p), pid, occ);
        end

        chk("flush_store_overlap", overlap_cnt, 0);
        chk("ready_with_error", ready_err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
